// File: rtl/parity_frame_pkg.sv
// Shared types and helpers for the parity serial frame transmitter.
// Build option: ODD_PARITY_EN selects odd parity; default is even parity.
package parity_frame_pkg;

    // Widest word calc_parity accepts; narrower words are zero-extended,
    // which does not change the XOR reduction.
    localparam int unsigned MAX_DATA_W = 64;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } frame_state_t;

    function automatic logic calc_parity(input logic [MAX_DATA_W-1:0] data);
`ifdef ODD_PARITY_EN
        return ~^data;
`else
        return ^data;
`endif
    endfunction

endpackage

// File: rtl/frame_bit_timer.sv
// Bit-period tick generator: tick is high on the last clk of every serial bit.
// Cleared on reset and when a new word is accepted so every frame starts aligned.
module frame_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    assign tick = (cnt == CNT_LAST);

    // Count 0..CLKS_PER_BIT-1, wrapping on every bit boundary.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/parity_frame_tx.sv
// Serial frame transmitter: start(0), data LSB-first, parity, stop(1), idle high.
// Build option: ODD_PARITY_EN (handled in parity_frame_pkg::calc_parity).
module parity_frame_tx
    import parity_frame_pkg::*;
#(
    parameter int unsigned DATA_W       = 4,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int unsigned BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    frame_state_t      state, state_next;
    logic [DATA_W-1:0] shreg, shreg_next;
    logic              par, par_next;
    logic [BIT_W-1:0]  bit_cnt, bit_cnt_next;
    logic              tx_next;
    logic              accept;
    logic              tick;

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign accept   = in_valid && in_ready;
    // Decoded straight from the state and timer flops, so it is a clean
    // single-cycle pulse on the final STOP clock and vanishes with reset.
    assign frame_done = (state == STOP) && tick;

    frame_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .reset(reset),
        .clear(accept),
        .tick (tick)
    );

    // State, shift register, parity, bit counter and line register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            shreg   <= '0;
            par     <= 1'b0;
            bit_cnt <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_next;
            shreg   <= shreg_next;
            par     <= par_next;
            bit_cnt <= bit_cnt_next;
            tx      <= tx_next;
        end
    end

    // Next-state, datapath updates, and the line value for the next cycle.
    always_comb begin
        state_next   = state;
        shreg_next   = shreg;
        par_next     = par;
        bit_cnt_next = bit_cnt;
        tx_next      = 1'b1;

        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_next   = START;
                    shreg_next   = in_data;
                    par_next     = calc_parity(MAX_DATA_W'(in_data));
                    bit_cnt_next = '0;
                end
            end
            START: begin
                if (tick) state_next = DATA;
            end
            DATA: begin
                if (tick) begin
                    shreg_next = shreg >> 1;
                    if (bit_cnt == BIT_LAST) begin
                        state_next   = PARITY;
                        bit_cnt_next = '0;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (tick) state_next = STOP;
            end
            STOP: begin
                if (tick) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // tx is registered: it carries the bit for the state being entered,
        // so the start bit appears the cycle right after the accepting edge.
        unique case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[0];
            PARITY:  tx_next = par_next;
            default: tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Directed self-checking bench for parity_frame_tx (CLKS_PER_BIT=4 and =1).
module tb_parity_frame_tx;

`ifdef ODD_PARITY_EN
    localparam logic ODD = 1'b1;
`else
    localparam logic ODD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] in_data = '0;
    logic       tx, busy, frame_done;

    logic       b_valid = 1'b0;
    logic       b_ready;
    logic [3:0] b_data = '0;
    logic       b_tx, b_busy, b_done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .tx(tx), .busy(busy), .frame_done(frame_done)
    );

    parity_frame_tx #(.DATA_W(4), .CLKS_PER_BIT(1)) dut_fast (
        .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
        .in_data(b_data), .tx(b_tx), .busy(b_busy), .frame_done(b_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a word to the CLKS_PER_BIT=4 instance for one accepting edge.
    task automatic accept(input logic [3:0] w);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = w;
        step();
        in_valid = 1'b0;
    endtask

    // Called one cycle after the accepting edge; checks all 28 frame cycles
    // and then the idle cycle that follows.
    task automatic check_frame_body(input logic [3:0] w, input logic p, input string name);
        logic exp_tx;
        for (int c = 1; c <= 28; c++) begin
            int b;
            b = (c - 1) / 4;
            if (b == 0)      exp_tx = 1'b0;
            else if (b <= 4) exp_tx = w[b-1];
            else if (b == 5) exp_tx = p;
            else             exp_tx = 1'b1;
            n_checks += 4;
            if (tx !== exp_tx) begin
                n_fail++;
                $display("FAIL %s_tx cyc%0d: tx=%b required %b", name, c, tx, exp_tx);
            end
            if (busy !== 1'b1) begin
                n_fail++;
                $display("FAIL %s_busy cyc%0d: busy=%b required 1", name, c, busy);
            end
            if (in_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL %s_ready cyc%0d: in_ready=%b required 0", name, c, in_ready);
            end
            if (frame_done !== (c == 28)) begin
                n_fail++;
                $display("FAIL %s_done cyc%0d: frame_done=%b required %b", name, c, frame_done, (c == 28));
            end
            step();
        end
        n_checks += 4;
        if (tx !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle_tx: tx=%b required 1", name, tx);
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_busy: busy=%b required 0", name, busy);
        end
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_idle_ready: in_ready=%b required 1", name, in_ready);
        end
        if (frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_idle_done: frame_done=%b required 0", name, frame_done);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks += 8;
        if (tx !== 1'b1)         begin n_fail++; $display("FAIL reset_tx: tx=%b required 1", tx); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL reset_busy: busy=%b required 0", busy); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: frame_done=%b required 0", frame_done); end
        if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL reset_ready: in_ready=%b required 1", in_ready); end
        if (b_tx !== 1'b1)       begin n_fail++; $display("FAIL reset_fast_tx: tx=%b required 1", b_tx); end
        if (b_busy !== 1'b0)     begin n_fail++; $display("FAIL reset_fast_busy: busy=%b required 0", b_busy); end
        if (b_done !== 1'b0)     begin n_fail++; $display("FAIL reset_fast_done: frame_done=%b required 0", b_done); end
        if (b_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_fast_ready: in_ready=%b required 1", b_ready); end
        reset = 1'b0;
        step();
    endtask

    // 1011: ones=3 -> even parity 1; line 0,1,1,0,1,1,1.
    task automatic test_frame_1011();
        accept(4'b1011);
        check_frame_body(4'b1011, 1'b1 ^ ODD, "f1011");
    endtask

    // 0000: even parity 0, odd parity 1.
    task automatic test_frame_zero();
        accept(4'b0000);
        check_frame_body(4'b0000, 1'b0 ^ ODD, "f0000");
    endtask

    task automatic test_sweep();
        logic [3:0] x;
        for (int i = 0; i < 16; i++) begin
            x = 4'(i);
            accept(x);
            check_frame_body(x, (^x) ^ ODD, "sweep");
        end
    endtask

    // 5 (two ones) and A (two ones): both even parity 0.
    task automatic test_back_to_back();
        in_valid = 1'b1;
        in_data  = 4'h5;
        step();
        in_data  = 4'hA;
        check_frame_body(4'h5, 1'b0 ^ ODD, "b2b_5");
        step();
        in_valid = 1'b0;
        check_frame_body(4'hA, 1'b0 ^ ODD, "b2b_A");
    endtask

    task automatic test_reset_abort();
        accept(4'b1111);
        for (int i = 0; i < 9; i++) step();
        n_checks += 2;
        if (tx !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_pre: tx=%b busy=%b required 1 1", tx, busy);
        end
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_pre_ready: in_ready=%b required 0", in_ready);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks += 4;
        if (tx !== 1'b1)         begin n_fail++; $display("FAIL abort_tx: tx=%b required 1", tx); end
        if (busy !== 1'b0)       begin n_fail++; $display("FAIL abort_busy: busy=%b required 0", busy); end
        if (in_ready !== 1'b1)   begin n_fail++; $display("FAIL abort_ready: in_ready=%b required 1", in_ready); end
        if (frame_done !== 1'b0) begin n_fail++; $display("FAIL abort_done: frame_done=%b required 0", frame_done); end
        for (int i = 0; i < 24; i++) begin
            step();
            n_checks++;
            if (frame_done !== 1'b0 || tx !== 1'b1) begin
                n_fail++;
                $display("FAIL abort_quiet cyc%0d: frame_done=%b tx=%b required 0 1", i, frame_done, tx);
            end
        end
        accept(4'b0110);
        check_frame_body(4'b0110, 1'b0 ^ ODD, "post_abort");
    endtask

    // CLKS_PER_BIT=1, 0110: line 0,0,1,1,0,p,1 with even p=0.
    task automatic test_fast_clk();
        logic [6:0] exp;
        exp = {1'b1, 1'b0 ^ ODD, 5'b01100};
        n_checks++;
        if (b_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_pre_busy: busy=%b required 0", b_busy);
        end
        b_valid = 1'b1;
        b_data  = 4'b0110;
        step();
        b_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            n_checks += 3;
            if (b_tx !== exp[c-1]) begin
                n_fail++;
                $display("FAIL fast_tx cyc%0d: tx=%b required %b", c, b_tx, exp[c-1]);
            end
            if (b_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL fast_busy cyc%0d: busy=%b required 1", c, b_busy);
            end
            if (b_done !== (c == 7)) begin
                n_fail++;
                $display("FAIL fast_done cyc%0d: frame_done=%b required %b", c, b_done, (c == 7));
            end
            step();
        end
        n_checks += 2;
        if (b_busy !== 1'b0 || b_tx !== 1'b1) begin
            n_fail++;
            $display("FAIL fast_end: busy=%b tx=%b required 0 1", b_busy, b_tx);
        end
        if (b_done !== 1'b0) begin
            n_fail++;
            $display("FAIL fast_end_done: frame_done=%b required 0", b_done);
        end
    endtask

    initial begin
        test_reset();
        test_frame_1011();
        test_frame_zero();
        test_sweep();
        test_back_to_back();
        test_reset_abort();
        test_fast_clk();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
